// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one single-port 64-bit memory between the
// instruction-fetch port and the data port. One request is served at a time:
// grant in IDLE, one memory strobe in ACCESS, read latency absorbed in WAIT,
// one-cycle ack in RESP. All outputs are registered.
module mem_arbiter_rr #(
  parameter int ADDR_BITS = 6,
  parameter int MEM_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [ADDR_BITS+2:0] i_addr,
  output logic [31:0]          i_rdata,
  output logic                 i_ack,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_BITS+2:0] d_addr,
  input  logic [63:0]          d_wdata,
  output logic [63:0]          d_rdata,
  output logic                 d_ack,
  output logic                 m_en,
  output logic                 m_we,
  output logic [ADDR_BITS-1:0] m_addr,
  output logic [63:0]          m_wdata,
  input  logic [63:0]          m_rdata,
  output logic                 busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t               r_state;
  logic                 r_last_d;
  logic                 r_sel;
  logic                 r_we;
  logic                 r_half;
  logic [CNT_W-1:0]     r_cnt;
  logic [31:0]          r_i_rdata;
  logic                 r_i_ack;
  logic [63:0]          r_d_rdata;
  logic                 r_d_ack;
  logic                 r_m_en;
  logic                 r_m_we;
  logic [ADDR_BITS-1:0] r_m_addr;
  logic [63:0]          r_m_wdata;
  logic                 r_busy;

  logic w_grant;
  logic w_grant_d;
  logic w_unused;

  // Data wins a tie only if the previous grant went to instruction fetch.
  assign w_grant   = i_req | d_req;
  assign w_grant_d = d_req & (~i_req | ~r_last_d);

  // Byte-offset bits below the word/half selection carry no information.
  assign w_unused = ^{i_addr[1:0], d_addr[2:0]};

  // Which 32-bit half of the word a fetch returns, latched with the grant.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_grant) begin
      r_half <= ~w_grant_d & i_addr[2];
    end
  end

  // Arbitration FSM: grant, strobe the memory once, wait out latency, ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last_d  <= 1'b1;
      r_sel     <= 1'b0;
      r_we      <= 1'b0;
      r_cnt     <= '0;
      r_i_rdata <= '0;
      r_i_ack   <= 1'b0;
      r_d_rdata <= '0;
      r_d_ack   <= 1'b0;
      r_m_en    <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_sel     <= w_grant_d;
            r_last_d  <= w_grant_d;
            r_we      <= w_grant_d & d_we;
            r_m_en    <= 1'b1;
            r_m_we    <= w_grant_d & d_we;
            r_m_addr  <= w_grant_d ? d_addr[ADDR_BITS+2:3] : i_addr[ADDR_BITS+2:3];
            r_m_wdata <= (w_grant_d & d_we) ? d_wdata : 64'h0;
            r_busy    <= 1'b1;
            r_state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_m_en    <= 1'b0;
          r_m_we    <= 1'b0;
          r_m_wdata <= 64'h0;
          if (r_we) begin
            r_d_ack <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt   <= CNT_LOAD;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            if (r_sel) begin
              r_d_rdata <= m_rdata;
              r_d_ack   <= 1'b1;
            end else begin
              r_i_rdata <= r_half ? m_rdata[63:32] : m_rdata[31:0];
              r_i_ack   <= 1'b1;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign i_rdata = r_i_rdata;
  assign i_ack   = r_i_ack;
  assign d_rdata = r_d_rdata;
  assign d_ack   = r_d_ack;
  assign m_en    = r_m_en;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign busy    = r_busy;

endmodule
